// File: rtl/tcp_flow_classifier.sv
// Pass-through stage with an 8-deep fallthrough FIFO, plus an on-the-fly Ethernet/IPv4/TCP
// header parser that emits a one-cycle data/ACK strobe with two direction-normalised flow hashes.
module tcp_flow_classifier #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int SRAM_ADDR_WIDTH = 19
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [CTRL_WIDTH-1:0]      in_ctrl,
   input  logic                       in_wr,
   output logic                       in_rdy,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [CTRL_WIDTH-1:0]      out_ctrl,
   output logic                       out_wr,
   input  logic                       out_rdy,
   output logic [SRAM_ADDR_WIDTH-1:0] hash_0,
   output logic [SRAM_ADDR_WIDTH-1:0] hash_1,
   output logic                       data_pkt,
   output logic                       ack_pkt
);
   localparam int W      = SRAM_ADDR_WIDTH;
   localparam int FW     = CTRL_WIDTH + DATA_WIDTH;
   localparam int DEPTH  = 8;
   localparam int NCHUNK = (96 + W - 1) / W;

   typedef enum logic [1:0] {S_HDR, S_PARSE, S_TAIL} state_t;

   logic [FW-1:0] mem_q [DEPTH];
   logic [2:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]    count_q, count_d;
   logic          push, pop, empty, nearly_full;

   assign empty       = (count_q == 4'd0);
   assign nearly_full = (count_q >= 4'(DEPTH - 1));
   assign in_rdy      = !nearly_full;
   assign push        = in_wr && in_rdy;
   assign out_wr      = !empty && out_rdy;
   assign pop         = out_wr;
   assign {out_ctrl, out_data} = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + 3'(push);
      rd_ptr_d = rd_ptr_q + 3'(pop);
      count_d  = count_q + 4'(push) - 4'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_ctrl, in_data};
   end

   state_t        state_q, state_d;
   logic [2:0]    wcnt_q, wcnt_d;
   logic          prev_nz_q, prev_nz_d;
   logic [15:0]   ethertype_q, ethertype_d, total_len_q, total_len_d;
   logic [3:0]    version_q, version_d, ihl_q, ihl_d;
   logic [7:0]    protocol_q, protocol_d;
   logic [31:0]   src_ip_q, src_ip_d;
   logic [15:0]   dst_hi_q, dst_hi_d, dst_lo_q, dst_lo_d;
   logic [15:0]   src_port_q, src_port_d, dst_port_q, dst_port_d;
   logic          data_pkt_q, data_pkt_d, ack_pkt_q, ack_pkt_d;
   logic [W-1:0]  hash_0_q, hash_0_d, hash_1_q, hash_1_d;

   logic          ctrl_last, eligible, is_data, is_ack;
   logic [16:0]   plen;
   logic [95:0]   key_data, key_ack, key_sel, key_rot;

   function automatic logic [W-1:0] fold(input logic [95:0] k);
      logic [NCHUNK*W-1:0] p;
      logic [W-1:0]        h;
      p       = '0;
      p[95:0] = k;
      h       = '0;
      for (int c = 0; c < NCHUNK; c++) h = h ^ p[c*W +: W];
      return h;
   endfunction

   // Word 5 is classified combinationally while it is being accepted; strobe is registered.
   assign ctrl_last = (in_ctrl != '0);
   assign plen      = {1'b0, total_len_q} - 17'd20 - {11'd0, in_data[15:12], 2'b00};
   assign eligible  = (ethertype_q == 16'h0800) && (version_q == 4'd4) &&
                      (ihl_q == 4'd5) && (protocol_q == 8'd6);
   assign is_data   = eligible && !plen[16] && (plen != 17'd0);
   assign is_ack    = eligible && (plen == 17'd0) && in_data[4];
   assign key_data  = {src_ip_q, dst_hi_q, dst_lo_q, src_port_q, dst_port_q};
   assign key_ack   = {dst_hi_q, dst_lo_q, src_ip_q, dst_port_q, src_port_q};
   assign key_sel   = is_ack ? key_ack : key_data;
   assign key_rot   = {key_sel[78:0], key_sel[95:79]};

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      prev_nz_d   = prev_nz_q;
      ethertype_d = ethertype_q;
      version_d   = version_q;
      ihl_d       = ihl_q;
      total_len_d = total_len_q;
      protocol_d  = protocol_q;
      src_ip_d    = src_ip_q;
      dst_hi_d    = dst_hi_q;
      dst_lo_d    = dst_lo_q;
      src_port_d  = src_port_q;
      dst_port_d  = dst_port_q;
      hash_0_d    = hash_0_q;
      hash_1_d    = hash_1_q;
      data_pkt_d  = 1'b0;
      ack_pkt_d   = 1'b0;
      if (push) begin
         prev_nz_d = ctrl_last;
         case (state_q)
            // Word 0 is only recognised on a ctrl!=0 -> ctrl==0 transition.
            S_HDR: begin
               if (!ctrl_last && prev_nz_q) begin
                  state_d = S_PARSE;
                  wcnt_d  = 3'd1;
               end
            end
            S_PARSE: begin
               wcnt_d = wcnt_q + 3'd1;
               case (wcnt_q)
                  3'd1: begin
                     ethertype_d = in_data[31:16];
                     version_d   = in_data[15:12];
                     ihl_d       = in_data[11:8];
                  end
                  3'd2: begin
                     total_len_d = in_data[63:48];
                     protocol_d  = in_data[7:0];
                  end
                  3'd3: begin
                     src_ip_d = in_data[47:16];
                     dst_hi_d = in_data[15:0];
                  end
                  3'd4: begin
                     dst_lo_d   = in_data[63:48];
                     src_port_d = in_data[47:32];
                     dst_port_d = in_data[31:16];
                  end
                  default: ;
               endcase
               if (wcnt_q == 3'd5) begin
                  data_pkt_d = is_data;
                  ack_pkt_d  = is_ack;
                  if (is_data || is_ack) begin
                     hash_0_d = fold(key_sel);
                     hash_1_d = fold(key_rot);
                  end
                  state_d = ctrl_last ? S_HDR : S_TAIL;
               end else if (ctrl_last) begin
                  state_d = S_HDR;
               end
            end
            S_TAIL: if (ctrl_last) state_d = S_HDR;
            default: state_d = S_HDR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_HDR;
         wcnt_q      <= '0;
         prev_nz_q   <= 1'b0;
         ethertype_q <= '0;
         version_q   <= '0;
         ihl_q       <= '0;
         total_len_q <= '0;
         protocol_q  <= '0;
         src_ip_q    <= '0;
         dst_hi_q    <= '0;
         dst_lo_q    <= '0;
         src_port_q  <= '0;
         dst_port_q  <= '0;
         hash_0_q    <= '0;
         hash_1_q    <= '0;
         data_pkt_q  <= 1'b0;
         ack_pkt_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         prev_nz_q   <= prev_nz_d;
         ethertype_q <= ethertype_d;
         version_q   <= version_d;
         ihl_q       <= ihl_d;
         total_len_q <= total_len_d;
         protocol_q  <= protocol_d;
         src_ip_q    <= src_ip_d;
         dst_hi_q    <= dst_hi_d;
         dst_lo_q    <= dst_lo_d;
         src_port_q  <= src_port_d;
         dst_port_q  <= dst_port_d;
         hash_0_q    <= hash_0_d;
         hash_1_q    <= hash_1_d;
         data_pkt_q  <= data_pkt_d;
         ack_pkt_q   <= ack_pkt_d;
      end
   end

   assign hash_0   = hash_0_q;
   assign hash_1   = hash_1_q;
   assign data_pkt = data_pkt_q;
   assign ack_pkt  = ack_pkt_q;
endmodule
